// File: rtl/fifo_pong_reader_pkg.sv
// Shared types for the ping-pong FIFO reader: the three-word item carried by the
// upstream FIFO and the reader's word-sequencing states.
package fifo_pong_reader_pkg;

    typedef struct packed {
        logic [31:0] c;
        logic [31:0] b;
        logic [31:0] a;
    } item_t;

    typedef enum logic [1:0] {
        ST_EMPTY  = 2'd0,
        ST_SEND_A = 2'd1,
        ST_SEND_B = 2'd2,
        ST_SEND_C = 2'd3
    } state_t;

endpackage

// File: rtl/fifo_pong_reader_if.sv
// Handshake bundle between the upstream ping-pong FIFO, the reader and the
// downstream word sink; master is the reader side, slave the surrounding system.
interface fifo_pong_reader_if;
    import fifo_pong_reader_pkg::*;

    item_t       in_first;
    logic        in_first_rdy;
    logic        in_deq_rdy;
    logic        in_deq_ena;
    logic [31:0] out_enq_v;
    logic        out_enq_rdy;
    logic        out_enq_ena;

    modport master (
        input  in_first,
        input  in_first_rdy,
        input  in_deq_rdy,
        input  out_enq_rdy,
        output in_deq_ena,
        output out_enq_v,
        output out_enq_ena
    );

    modport slave (
        output in_first,
        output in_first_rdy,
        output in_deq_rdy,
        output out_enq_rdy,
        input  in_deq_ena,
        input  out_enq_v,
        input  out_enq_ena
    );
endinterface

// File: rtl/fifo_pong_reader.sv
// Dequeues 96-bit items from a ping-pong FIFO and streams each one downstream as
// three 32-bit words (a, b, c), reloading in the last word's cycle to avoid bubbles.
module fifo_pong_reader
    import fifo_pong_reader_pkg::*;
#(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 CLK,
    input  logic                 nRST,
    fifo_pong_reader_if.master   bus,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 busy
);

    state_t                state_q, state_d;
    item_t                 hold_q, hold_d;
    logic [CNT_WIDTH-1:0]  count_q, count_d;
    logic                  busy_s;
    logic                  xfer_s;
    logic                  load_s;
    logic [31:0]           word_s;

    // Next-state, hold capture, item counter and handshake decode.
    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        count_d = count_q;
        busy_s  = (state_q != ST_EMPTY);
        xfer_s  = busy_s & bus.out_enq_rdy;
        // Gated by nRST so no dequeue is signalled while the block is held in reset.
        load_s  = nRST & bus.in_first_rdy & bus.in_deq_rdy &
                  ((state_q == ST_EMPTY) | ((state_q == ST_SEND_C) & bus.out_enq_rdy));

        case (state_q)
            ST_EMPTY: begin
                if (load_s) state_d = ST_SEND_A;
                else        state_d = ST_EMPTY;
            end
            ST_SEND_A: begin
                if (xfer_s) state_d = ST_SEND_B;
                else        state_d = ST_SEND_A;
            end
            ST_SEND_B: begin
                if (xfer_s) state_d = ST_SEND_C;
                else        state_d = ST_SEND_B;
            end
            ST_SEND_C: begin
                if (xfer_s) begin
                    state_d = load_s ? ST_SEND_A : ST_EMPTY;
                    count_d = count_q + {{(CNT_WIDTH-1){1'b0}}, 1'b1};
                end else begin
                    state_d = ST_SEND_C;
                end
            end
            default: state_d = ST_EMPTY;
        endcase

        if (load_s) hold_d = bus.in_first;
        else        hold_d = hold_q;
    end

    // Select the word for the current state straight from registered state.
    always_comb begin
        word_s = 32'd0;
        case (state_q)
            ST_SEND_A: word_s = hold_q.a;
            ST_SEND_B: word_s = hold_q.b;
            ST_SEND_C: word_s = hold_q.c;
            ST_EMPTY:  word_s = 32'd0;
            default:   word_s = 32'd0;
        endcase
    end

    // State, held item and completed-item counter registers.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            state_q <= ST_EMPTY;
            hold_q  <= '0;
            count_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            count_q <= count_d;
        end
    end

    assign bus.in_deq_ena  = load_s;
    assign bus.out_enq_ena = xfer_s;
    assign bus.out_enq_v   = word_s;
    assign count           = count_q;
    assign busy            = busy_s;

endmodule

// File: tb/tb_fifo_pong_reader.sv
// Directed bench for fifo_pong_reader: single item, back-to-back, stall, empty
// upstream, mid-item reset and counter wrap on a narrow-counter instance.
module tb_fifo_pong_reader;
    import fifo_pong_reader_pkg::*;

    logic        CLK;
    logic        nRST;
    logic [15:0] count;
    logic        busy;
    logic [1:0]  count2;
    logic        busy2;
    int          total;
    int          bad;

    fifo_pong_reader_if bus ();
    fifo_pong_reader_if bus2 ();

    fifo_pong_reader #(.CNT_WIDTH(16)) dut (
        .CLK   (CLK),
        .nRST  (nRST),
        .bus   (bus.master),
        .count (count),
        .busy  (busy)
    );

    fifo_pong_reader #(.CNT_WIDTH(2)) dut2 (
        .CLK   (CLK),
        .nRST  (nRST),
        .bus   (bus2.master),
        .count (count2),
        .busy  (busy2)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Advance one cycle; inputs are set and outputs checked #1 after the falling edge.
    task automatic nxt();
        @(negedge CLK);
        #1;
    endtask

    task automatic chk_word(input string tag, input logic [31:0] v, input logic ena);
        chk({tag, ".v"}, bus.out_enq_v, v);
        chk({tag, ".ena"}, 32'(bus.out_enq_ena), 32'(ena));
    endtask

    initial begin
        total = 0;
        bad   = 0;
        nRST  = 1'b0;
        bus.in_first      = '0;
        bus.in_first_rdy  = 1'b1;
        bus.in_deq_rdy    = 1'b1;
        bus.out_enq_rdy   = 1'b1;
        bus2.in_first     = '0;
        bus2.in_first_rdy = 1'b0;
        bus2.in_deq_rdy   = 1'b0;
        bus2.out_enq_rdy  = 1'b0;

        // Reset state, with upstream ready so dequeue must still be held off
        nxt();
        nxt();
        chk("rst.count", 32'(count), 32'd0);
        chk("rst.busy", 32'(busy), 32'd0);
        chk("rst.deq", 32'(bus.in_deq_ena), 32'd0);
        chk_word("rst", 32'd0, 1'b0);

        // Single item loaded in the first cycle after release
        nRST = 1'b1;
        bus.in_first = '{c: 32'd3, b: 32'd2, a: 32'd1};
        #1;
        chk("s0.deq", 32'(bus.in_deq_ena), 32'd1);
        chk("s0.busy", 32'(busy), 32'd0);
        nxt();
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("s1", 32'd1, 1'b1);
        chk("s1.busy", 32'(busy), 32'd1);
        nxt();
        chk_word("s2", 32'd2, 1'b1);
        nxt();
        chk_word("s3", 32'd3, 1'b1);
        chk("s3.deq", 32'(bus.in_deq_ena), 32'd0);
        nxt();
        chk("s4.busy", 32'(busy), 32'd0);
        chk("s4.count", 32'(count), 32'd1);
        chk_word("s4", 32'd0, 1'b0);

        // Back-to-back items with no bubble
        bus.in_first = '{c: 32'd3, b: 32'd2, a: 32'd1};
        bus.in_first_rdy = 1'b1;
        #1;
        chk("bb0.deq", 32'(bus.in_deq_ena), 32'd1);
        nxt();
        bus.in_first = '{c: 32'd6, b: 32'd5, a: 32'd4};
        #1;
        chk_word("bb1", 32'd1, 1'b1);
        chk("bb1.deq", 32'(bus.in_deq_ena), 32'd0);
        nxt();
        chk_word("bb2", 32'd2, 1'b1);
        nxt();
        chk_word("bb3", 32'd3, 1'b1);
        chk("bb3.deq", 32'(bus.in_deq_ena), 32'd1);
        nxt();
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("bb4", 32'd4, 1'b1);
        nxt();
        chk_word("bb5", 32'd5, 1'b1);
        chk("bb5.count", 32'(count), 32'd2);
        nxt();
        chk_word("bb6", 32'd6, 1'b1);
        nxt();
        chk("bb7.count", 32'(count), 32'd3);
        chk("bb7.busy", 32'(busy), 32'd0);

        // Downstream stall in SEND_B while upstream changes its head item
        bus.in_first = '{c: 32'd3, b: 32'd2, a: 32'd1};
        bus.in_first_rdy = 1'b1;
        nxt();
        chk_word("st1", 32'd1, 1'b1);
        nxt();
        bus.out_enq_rdy = 1'b0;
        bus.in_first = '{c: 32'hFFFF_FFFF, b: 32'hFFFF_FFFF, a: 32'hFFFF_FFFF};
        #1;
        for (int i = 0; i < 4; i++) begin
            chk_word("st.hold", 32'd2, 1'b0);
            chk("st.deq", 32'(bus.in_deq_ena), 32'd0);
            chk("st.busy", 32'(busy), 32'd1);
            nxt();
        end
        bus.out_enq_rdy  = 1'b1;
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("st.res_b", 32'd2, 1'b1);
        nxt();
        chk_word("st.res_c", 32'd3, 1'b1);
        nxt();
        chk("st.count", 32'(count), 32'd4);

        // Empty upstream during SEND_C, then deq-ready low blocks a load
        bus.in_first = '{c: 32'd13, b: 32'd12, a: 32'd11};
        bus.in_first_rdy = 1'b1;
        nxt();
        chk_word("em1", 32'd11, 1'b1);
        nxt();
        bus.in_first_rdy = 1'b0;
        nxt();
        chk_word("em3", 32'd13, 1'b1);
        chk("em3.deq", 32'(bus.in_deq_ena), 32'd0);
        nxt();
        chk("em4.busy", 32'(busy), 32'd0);
        chk_word("em4", 32'd0, 1'b0);
        chk("em4.deq", 32'(bus.in_deq_ena), 32'd0);
        bus.in_first = '{c: 32'd23, b: 32'd22, a: 32'd21};
        bus.in_first_rdy = 1'b1;
        bus.in_deq_rdy   = 1'b0;
        #1;
        chk("em4.deqrdy_low", 32'(bus.in_deq_ena), 32'd0);
        nxt();
        chk("em5.busy", 32'(busy), 32'd0);
        bus.in_deq_rdy = 1'b1;
        #1;
        chk("em5.deq", 32'(bus.in_deq_ena), 32'd1);
        nxt();
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("em6", 32'd21, 1'b1);
        chk("em6.count", 32'(count), 32'd5);
        nxt();
        nxt();
        nxt();
        chk("em.count", 32'(count), 32'd6);

        // Reset asserted while in SEND_B discards the held item
        bus.in_first = '{c: 32'd33, b: 32'd32, a: 32'd31};
        bus.in_first_rdy = 1'b1;
        nxt();
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("rm1", 32'd31, 1'b1);
        nxt();
        chk_word("rm2", 32'd32, 1'b1);
        nRST = 1'b0;
        #1;
        chk_word("rm.async", 32'd0, 1'b0);
        chk("rm.busy", 32'(busy), 32'd0);
        chk("rm.count", 32'(count), 32'd0);
        chk("rm.deq", 32'(bus.in_deq_ena), 32'd0);
        nxt();
        nRST = 1'b1;
        bus.in_first = '{c: 32'd43, b: 32'd42, a: 32'd41};
        bus.in_first_rdy = 1'b1;
        #1;
        chk("rm.reload_deq", 32'(bus.in_deq_ena), 32'd1);
        nxt();
        bus.in_first_rdy = 1'b0;
        #1;
        chk_word("rm.a_first", 32'd41, 1'b1);
        nxt();
        nxt();
        nxt();
        chk("rm.count_after", 32'(count), 32'd1);

        // Narrow counter wraps after four items under continuous traffic
        bus2.in_first     = '{c: 32'd9, b: 32'd8, a: 32'd7};
        bus2.in_first_rdy = 1'b1;
        bus2.in_deq_rdy   = 1'b1;
        bus2.out_enq_rdy  = 1'b1;
        #1;
        chk("wr.deq0", 32'(bus2.in_deq_ena), 32'd1);
        nxt();
        for (int k = 1; k <= 5; k++) begin
            repeat (3) nxt();
            chk("wr.count", 32'(count2), 32'(k % 4));
        end
        chk("wr.busy", 32'(busy2), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/fifo_pong_reader.md
FIFO_PONG_READER -- requirements
Module: fifo_pong_reader

Interface
REQ-001 Parameter CNT_WIDTH, default 16: width of the completed-item counter.
REQ-002 CLK  input  1: single clock; all state changes on rising edge.
REQ-003 nRST  input  1: reset, asynchronous assert, active-low.
REQ-004 in$first  input  96: head item of the upstream ping-pong FIFO; fields c[95:64], b[63:32], a[31:0].
REQ-005 in$first__RDY  input  1: in$first is valid.
REQ-006 in$deq__RDY  input  1: upstream can dequeue.
REQ-007 in$deq__ENA  output  1: dequeue the head item this cycle.
REQ-008 out$enq$v  output  32: word presented downstream.
REQ-009 out$enq__RDY  input  1: downstream accepts a word this cycle.
REQ-010 out$enq__ENA  output  1: word transfer occurs this cycle.
REQ-011 count  output  CNT_WIDTH: number of items fully emitted, modulo 2^CNT_WIDTH.
REQ-012 busy  output  1: a held item is not yet fully emitted.

Function
REQ-013 The block SHALL read 96-bit items from a ping-pong FIFO and emit each one as three 32-bit words in order a, b, c.
REQ-014 States SHALL be EMPTY, SEND_A, SEND_B and SEND_C; busy = (state != EMPTY).
REQ-015 load = in$first__RDY & in$deq__RDY & (state==EMPTY | (state==SEND_C & out$enq__RDY)).
REQ-016 in$deq__ENA SHALL equal load; on load, in$first SHALL be captured into a 96-bit hold register and state SHALL become SEND_A.
REQ-017 out$enq__ENA SHALL equal busy & out$enq__RDY; it SHALL never assert while out$enq__RDY is low.
REQ-018 out$enq$v SHALL be hold.a in SEND_A, hold.b in SEND_B, hold.c in SEND_C, and 0 in EMPTY.
REQ-019 On a transfer, SEND_A SHALL go to SEND_B and SEND_B SHALL go to SEND_C.
REQ-020 On a transfer in SEND_C, the block SHALL go to SEND_A if load, else to EMPTY; count SHALL increment by 1.
REQ-021 Without a transfer, state, hold and out$enq$v SHALL stay unchanged (downstream stall).
REQ-022 Latency: the first word SHALL be presented in the cycle after load; sustained throughput SHALL be one word per cycle, with no bubble between items.
REQ-023 The hold register SHALL change only on load; upstream changes to in$first while busy SHALL be ignored.
REQ-024 count SHALL wrap from 2^CNT_WIDTH-1 to 0 without flagging.
REQ-025 The block SHALL never assert in$deq__ENA while in$deq__RDY or in$first__RDY is low.

Reset
REQ-026 While nRST=0: state=EMPTY, hold=0, count=0, busy=0, out$enq__ENA=0, in$deq__ENA=0, out$enq$v=0.
REQ-027 Reset during SEND_A/B/C SHALL discard the held item, which was already dequeued; count SHALL NOT include it.
REQ-028 The first load SHALL be possible in the first rising edge after nRST deasserts.

Structure
REQ-029 A shared package SHALL hold the three-field 32-bit item struct (a, b, c) and the four-value state enum; the upstream FIFO uses the same struct.
REQ-030 The design SHALL be a single module with no sub-modules, intended to sit directly on the out side of the ping-pong FIFO.

Verification
REQ-031 Single item: with out$enq__RDY=1, item {c=3,b=2,a=1} loaded at cycle 0 -> words 1, 2, 3 at cycles 1-3; count=1; busy=0 at cycle 4.
REQ-032 Back-to-back: items {3,2,1} and {6,5,4}, both available -> six words 1..6 on consecutive cycles; in$deq__ENA asserted at cycle 0 and cycle 3; count=2.
REQ-033 Stall: drop out$enq__RDY for 4 cycles in SEND_B with in$first changed to 0xFFFF_FFFF -> out$enq$v holds 2 and no deq occurs; resumes with 2, then 3.
REQ-034 Empty upstream: hold in$first__RDY=0 during SEND_C -> after word c the state is EMPTY, out$enq__ENA=0, and in$deq__ENA stays 0 until RDY returns.
REQ-035 Reset mid-item: assert nRST in SEND_B -> all outputs are 0 immediately (asynchronous), count=0, and the next item after release emits a-first.
REQ-036 Wrap: CNT_WIDTH=2, emit 5 items -> count sequence 1, 2, 3, 0, 1.
